// File: rtl/jtframe_db15_tx_if.sv
// Pin bundle between a DB15 serial joystick reader (master) and the adapter model (slave).
// Strobes: joy_load low loads/holds the frame, its rise starts shifting; each joy_clk rise
// consumes one bit; joy_data is sampled by the master before the next joy_clk rise.
interface jtframe_db15_tx_if #(
  parameter int PLAYER_BITS = 8
);
  logic [PLAYER_BITS-1:0] joy1;
  logic [PLAYER_BITS-1:0] joy2;
  logic                   joy_clk;
  logic                   joy_load;
  logic                   joy_data;
  logic                   busy;
  logic                   frame_done;
  logic                   stale;

  modport master (
    output joy1, joy2, joy_clk, joy_load,
    input  joy_data, busy, frame_done, stale
  );

  modport slave (
    input  joy1, joy2, joy_clk, joy_load,
    output joy_data, busy, frame_done, stale
  );
endinterface

// File: rtl/jtframe_db15_tx.sv
// DB15 serial joystick adapter model: emulates cascaded 74HC165s driven by JOY_CLK/JOY_LOAD.
// Optional load watchdog enabled by defining JTFRAME_DB15_TX_WDOG_EN.
module jtframe_db15_tx #(
  parameter int PLAYER_BITS = 8,
  parameter int WDOG_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  jtframe_db15_tx_if.slave      bus,
  output logic [1:0]            dbg_state_o
);
  localparam int FW = 2 * PLAYER_BITS;
  localparam int CW = $clog2(FW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  logic          clk_meta_q, clk_s_q, clk_d_q;
  logic          load_meta_q, load_s_q, load_d_q;
  state_t        state_q, state_d;
  logic [FW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          clk_rise, load_rise;
  logic [FW-1:0] frame_w;

  // Load idles high so reset never fakes a parallel load.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b0;
      clk_s_q     <= 1'b0;
      clk_d_q     <= 1'b0;
      load_meta_q <= 1'b1;
      load_s_q    <= 1'b1;
      load_d_q    <= 1'b1;
    end else begin
      clk_meta_q  <= bus.joy_clk;
      clk_s_q     <= clk_meta_q;
      clk_d_q     <= clk_s_q;
      load_meta_q <= bus.joy_load;
      load_s_q    <= load_meta_q;
      load_d_q    <= load_s_q;
    end
  end

  assign clk_rise  = clk_s_q & ~clk_d_q;
  assign load_rise = load_s_q & ~load_d_q;
  assign frame_w   = {~bus.joy1, ~bus.joy2};

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (!load_s_q) begin
      // Low load dominates: transparent reload, any pending shift is dropped.
      state_d = ST_LOAD;
      sr_d    = frame_w;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (load_rise) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            sr_d  = {sr_q[FW-2:0], 1'b1};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (clk_rise) sr_d = {sr_q[FW-2:0], 1'b1};
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      sr_q    <= '1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.joy_data   = sr_q[FW-1];
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.frame_done = done_q;
  assign dbg_state_o    = state_q;

`ifdef JTFRAME_DB15_TX_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYCLES);

  logic          load_fall;
  logic [WW-1:0] wdog_q, wdog_d;

  assign load_fall = ~load_s_q & load_d_q;

  always_comb begin
    wdog_d = wdog_q;
    if (load_fall)               wdog_d = '0;
    else if (wdog_q != WDOG_MAX) wdog_d = wdog_q + WW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wdog_q <= '0;
    else     wdog_q <= wdog_d;
  end

  assign bus.stale = (wdog_q == WDOG_MAX);
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign bus.stale   = 1'b0;
`endif
endmodule

// File: tb/tb_jtframe_db15_tx.sv
// Bench for jtframe_db15_tx: behavioural frame model checked every cycle plus literal frames.
module tb_jtframe_db15_tx;
  localparam int PB = 8;
  localparam int FW = 2 * PB;
  localparam int WD = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;
  bit         started = 1'b0;

  jtframe_db15_tx_if #(.PLAYER_BITS(PB)) bus ();

  jtframe_db15_tx #(.PLAYER_BITS(PB), .WDOG_CYCLES(WD)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_seen = 0;
  logic [0:0] exp_q[$];

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the frame word, how many bits the master has consumed, and whether a
  // load rise has armed the frame. Pins reach the logic two clk edges late (lh/ch histories).
  logic [FW-1:0] m_word;
  int            m_k;
  bit            m_armed;
  int            m_wcnt;
  logic [2:0]    lh, ch;
  logic          m_ls, m_ld, m_cs, m_cd;
  logic          e_data, e_busy, e_done, e_stale;

  always @(posedge clk) begin
    if (rst) begin
      m_word = '1; m_k = 0; m_armed = 0; m_wcnt = 0;
      lh = '1; ch = '0; e_done = 1'b0;
    end else begin
      m_ls = lh[1]; m_ld = lh[2]; m_cs = ch[1]; m_cd = ch[2];
      e_done = 1'b0;
      if (!m_ls) begin
        m_armed = 0; m_k = 0; m_word = {~bus.joy1, ~bus.joy2};
      end else if (!m_ld) begin
        m_armed = 1;
      end else if (m_armed && m_cs && !m_cd && m_k < FW) begin
        m_k++;
        e_done = (m_k == FW);
      end
      if (!m_ls && m_ld) m_wcnt = 0;
      else if (m_wcnt < WD) m_wcnt++;
      lh = {lh[1:0], bus.joy_load};
      ch = {ch[1:0], bus.joy_clk};
    end
    e_data = (m_k >= FW) ? 1'b1 : m_word[FW-1-m_k];
    e_busy = m_armed && (m_k < FW);
`ifdef JTFRAME_DB15_TX_WDOG_EN
    e_stale = (m_wcnt == WD);
`else
    e_stale = 1'b0;
`endif
  end

  always @(negedge clk) begin
    if (!rst && started) begin
      check_bit("joy_data", bus.joy_data, e_data);
      check_bit("busy", bus.busy, e_busy);
      check_bit("frame_done", bus.frame_done, e_done);
      check_bit("stale", bus.stale, e_stale);
      check_bit("state_legal", dbg_state != 2'b11, 1'b1);
      if (bus.frame_done) done_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int lo);
    bus.joy_load = 1'b0;
    idle(lo);
    bus.joy_load = 1'b1;
    idle(6);
  endtask

  task automatic do_pulse(input int hi, input int lo);
    bus.joy_clk = 1'b1;
    idle(hi);
    bus.joy_clk = 1'b0;
    idle(lo);
  endtask

  task automatic read_frame(input int n, input int chg_at, input logic [PB-1:0] chg_val,
                            input int hold);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) check_bit("serial_bit", bus.joy_data, exp_q.pop_front());
      if (i == chg_at) bus.joy1 = chg_val;
      do_pulse(hold, hold);
    end
  endtask

  task automatic push_literal(input int n);
    logic [FW-1:0] lit;
    lit = 16'b0111_1110_1111_1111;
    for (int i = 0; i < n; i++) exp_q.push_back(i < FW ? lit[FW-1-i] : 1'b1);
  endtask

  task automatic push_frame(input logic [PB-1:0] j1, input logic [PB-1:0] j2, input int n);
    logic [FW-1:0] w;
    w = {~j1, ~j2};
    for (int i = 0; i < n; i++) exp_q.push_back(i < FW ? w[FW-1-i] : 1'b1);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    bus.joy_load = 1'b1; bus.joy_clk = 1'b0; bus.joy1 = '0; bus.joy2 = '0;
    idle(4);
    rst = 1'b0;
    started = 1'b1;
    idle(1);
    check_bit("rst_data", bus.joy_data, 1'b1);
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_done", bus.frame_done, 1'b0);

    // Full frame of 8'h81/8'h00 with the frame_done timing pinned.
    bus.joy1 = 8'h81; bus.joy2 = 8'h00;
    d0 = done_seen;
    do_load(8);
    check_bit("busy_armed", bus.busy, 1'b1);
    push_literal(FW);
    read_frame(FW - 1, -1, '0, 8);
    check_bit("serial_bit", bus.joy_data, exp_q.pop_front());
    bus.joy_clk = 1'b1;
    idle(2);
    check_bit("done_early", bus.frame_done, 1'b0);
    idle(1);
    check_bit("done_at_3", bus.frame_done, 1'b1);
    idle(1);
    check_bit("done_width", bus.frame_done, 1'b0);
    idle(4);
    bus.joy_clk = 1'b0;
    idle(8);
    check_int("done_count_full", done_seen - d0, 1);
    check_bit("busy_after", bus.busy, 1'b0);
    check_bit("data_after", bus.joy_data, 1'b1);

    // joy1 change mid-shift must not reach the frozen frame.
    d0 = done_seen;
    do_load(5);
    push_literal(FW);
    read_frame(FW, 4, 8'hFF, 5);
    check_int("done_count_latch", done_seen - d0, 1);
    bus.joy1 = 8'h81;

    // Abort after 5 edges.
    d0 = done_seen;
    do_load(5);
    push_literal(5);
    read_frame(5, -1, '0, 4);
    bus.joy_load = 1'b0;
    idle(4);
    check_bit("abort_busy", bus.busy, 1'b0);
    check_bit("abort_data", bus.joy_data, 1'b0);
    bus.joy_load = 1'b1;
    idle(6);
    check_int("abort_no_done", done_seen - d0, 0);

    // Overclocked frame: 20 edges, counter saturates.
    d0 = done_seen;
    do_load(4);
    push_literal(20);
    read_frame(20, -1, '0, 4);
    check_int("done_count_20", done_seen - d0, 1);
    check_bit("over_data", bus.joy_data, 1'b1);
    check_bit("over_busy", bus.busy, 1'b0);

    // Watchdog idle and clear.
    idle(WD + 20);
`ifdef JTFRAME_DB15_TX_WDOG_EN
    check_bit("stale_set", bus.stale, 1'b1);
`else
    check_bit("stale_off", bus.stale, 1'b0);
`endif
    do_load(5);
    check_bit("stale_clear", bus.stale, 1'b0);

    // Reset mid-frame with joy_clk held high.
    read_frame(3, -1, '0, 4);
    bus.joy_clk = 1'b1;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_bit("midrst_data", bus.joy_data, 1'b1);
    check_bit("midrst_busy", bus.busy, 1'b0);
    check_bit("midrst_done", bus.frame_done, 1'b0);
    bus.joy_clk = 1'b0;
    idle(6);

    // Randomized frames, including aborts, overclocking and mid-frame input churn.
    for (int t = 0; t < 30; t++) begin
      logic [PB-1:0] j1, j2, jn;
      int n, hold;
      j1 = PB'($urandom); j2 = PB'($urandom); jn = PB'($urandom);
      n = $urandom_range(0, 20);
      hold = $urandom_range(4, 7);
      bus.joy1 = j1; bus.joy2 = j2;
      exp_q.delete();
      push_frame(j1, j2, n);
      d0 = done_seen;
      do_load($urandom_range(4, 10));
      read_frame(n, $urandom_range(0, 15), jn, hold);
      bus.joy2 = PB'($urandom);
      idle($urandom_range(1, 10));
      check_int("rand_done_count", done_seen - d0, (n >= FW) ? 1 : 0);
    end

    idle(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/jtframe_db15_tx.md
Name: jtframe_db15_tx

Overview:
- Device-side model of the serial DB15 joystick adapter: the responder to the frame's JOY_CLK/JOY_LOAD/JOY_DATA reader.
- Emulates the adapter's cascaded parallel-in/serial-out shift registers. It latches two player button vectors and shifts them out on the data line under master-generated load/clock strobes.
- Used in simulation benches in place of real hardware, and in loopback/bridge cores that feed a DB15 reader.

Parameters:
- PLAYER_BITS, 8, bits per player; the frame is 2*PLAYER_BITS long.
- WDOG_CYCLES, 1000000, clk cycles without a load pulse before `stale` asserts (optional feature only).

Ports:
- clk  in  1  system clock; joy_clk/joy_load are oversampled in this domain.
- rst  in  1  synchronous reset, active-high.
- joy1  in  PLAYER_BITS  player 1 buttons, 1 = pressed.
- joy2  in  PLAYER_BITS  player 2 buttons, 1 = pressed.
- joy_clk  in  1  shift clock from master, asynchronous; shifts on rising edge.
- joy_load  in  1  parallel load from master, asynchronous, active-low.
- joy_data  out  1  serial data to master; active-low (0 = pressed).
- busy  out  1  high while a frame is being shifted.
- frame_done  out  1  one-cycle pulse when the last frame bit has been consumed.
- stale  out  1  watchdog flag (optional feature; otherwise tied 0).

Behaviour:
- Input conditioning:
  - joy_clk and joy_load each pass through a 2-FF synchronizer, giving clk_s and load_s.
  - A third register provides edge detection.
  - Pin-to-action latency is 3 clk cycles.
  - The master must hold each joy_clk and joy_load level for at least 4 clk cycles; shorter pulses are undefined.
- Frame word: W = {~joy1, ~joy2}, width 2*PLAYER_BITS. It is sent MSB first, so bit joy1[PLAYER_BITS-1] goes out first.
- Reset values: shift register all ones, joy_data=1, busy=0, frame_done=0, stale=0, bit counter=0, state LOAD.
- State LOAD (entered while load_s=0):
  - The shift register reloads from W every cycle (transparent, as in a 74HC165).
  - joy_data = W[MSB].
  - Bit counter is cleared, busy=0, clk_s edges are ignored.
- State LOAD -> SHIFT on load_s rising edge:
  - The shift register freezes.
  - joy1/joy2 changes after this point do not affect the current frame.
  - busy=1.
- State SHIFT:
  - On each clk_s rising edge, the register shifts left, a 1 (released) enters at the LSB, and the counter increments.
  - joy_data always equals the register MSB and updates the cycle after the detected edge.
- Frame end:
  - When the counter reaches 2*PLAYER_BITS, frame_done pulses for exactly 1 cycle, busy=0, and the state becomes DONE.
- State DONE:
  - Further clk_s edges keep shifting in ones; joy_data=1.
  - No further frame_done pulses.
  - The counter saturates and does not wrap.
- load_s falling edge in any state goes to LOAD immediately. This aborts a partial frame: no frame_done, busy drops the same cycle.
- Simultaneous clk_s edge and load_s low: load wins and the shift is discarded.
- rst asserted mid-frame returns to the reset values on the next clk edge, regardless of joy_clk/joy_load.

Optional Feature:
- Macro JTFRAME_DB15_TX_WDOG_EN.
- When defined:
  - A counter of ceil(log2(WDOG_CYCLES+1)) bits increments every clk and clears on each load_s falling edge.
  - On reaching WDOG_CYCLES it saturates and sets stale=1.
  - stale clears on the next load_s falling edge.
- When undefined: no counter, stale is constant 0.

Test Plan:
- Reset release with joy_load=1 and joy_clk=0 -> joy_data=1, busy=0, frame_done=0.
- joy1=8'h81, joy2=8'h00, load low 8 cycles then high, then 16 joy_clk pulses (8 high/8 low) -> joy_data sequence 0,1,1,1,1,1,1,0 then eight 1s; busy high during the frame; single frame_done pulse 3 cycles after the 16th rising edge.
- Change joy1 to 8'hFF after load rises but mid-shift -> remaining bits still match the latched 8'h81 value.
- Load pulse after 5 joy_clk edges -> no frame_done, busy drops, joy_data returns to ~joy1[7].
- 20 joy_clk edges in one frame -> bits 17-20 read 1, exactly one frame_done, counter does not wrap.
- With JTFRAME_DB15_TX_WDOG_EN and WDOG_CYCLES=100, no load for 100 cycles -> stale=1 at cycle 100; next load falling edge -> stale=0. Without the macro -> stale stays 0.
